// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes and a registered result/flag stage.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add signed multiplier for opcode 111.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic signed [WIDTH-1:0] Data1,
    input  logic signed [WIDTH-1:0] Data2,
    input  logic        [2:0]       Select,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic signed [WIDTH-1:0] Result,
    output logic                    Zero,
    output logic                    Carry,
    output logic                    Overflow
);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    logic               mul_start, mul_done, mul_ovf;
    logic [2*WIDTH-1:0] mul_prod;

    // Reset_n gates InReady so it reads 0 for the whole time reset is held.
    assign InReady = Reset_n && (state_q == S_IDLE) && (!valid_q || OutReady);
    assign accept  = InValid && InReady;

    assign add_full = {1'b0, Data1} + {1'b0, Data2};
    assign sub_full = {1'b0, Data1} - {1'b0, Data2};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (Select)
            3'b000: alu_res = Data1;
            3'b001: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (Data1[WIDTH-1] == Data2[WIDTH-1]) && (add_full[WIDTH-1] != Data1[WIDTH-1]);
            end
            3'b010: alu_res = Data1 & Data2;
            3'b011: alu_res = Data1 | Data2;
            3'b100: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (Data1[WIDTH-1] != Data2[WIDTH-1]) && (sub_full[WIDTH-1] != Data1[WIDTH-1]);
            end
            3'b101: alu_res = Data1 ^ Data2;
            3'b110: alu_res = {{(WIDTH-1){1'b0}}, (Data1 < Data2)};
            default: alu_v  = 1'b1;  // opcode 111 without a multiplier: zero result, overflow set
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, pp;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    assign mul_start = accept && (Select == 3'b111);
    assign mul_done  = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));
    assign pp        = mplier_q[0] ? mcand_q : '0;
    // The multiplier's MSB carries negative weight, so the last partial product is subtracted.
    assign mul_prod  = mul_done ? (acc_q - pp) : (acc_q + pp);
    assign mul_ovf   = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || !(|mul_prod[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (mul_start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{Data1[WIDTH-1]}}, Data1};
            mplier_d = Data2;
            cnt_d    = '0;
        end else if (state_q == S_MUL) begin
            acc_d    = mul_prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign mul_start = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
    assign mul_ovf   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (valid_q && OutReady) begin
            valid_d = 1'b0;
        end
        if (accept && !mul_start) begin
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
            valid_d = 1'b1;
        end
        if (mul_start) begin
            state_d = S_MUL;
        end
        if (mul_done) begin
            res_d   = mul_prod[WIDTH-1:0];
            zero_d  = (mul_prod[WIDTH-1:0] == '0);
            carry_d = 1'b0;
            ovf_d   = mul_ovf;
            valid_d = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OutValid = valid_q;
    assign Result   = res_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 The block SHALL have port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port InValid  input  1  operand/opcode presented this cycle.
REQ-005 The block SHALL have port InReady  output  1  block accepts operands this cycle.
REQ-006 The block SHALL have ports Data1 and Data2  input  WIDTH each  signed two's-complement operands.
REQ-007 The block SHALL have port Select  input  3  opcode.
REQ-008 The block SHALL have port OutValid  output  1  Result and flags valid.
REQ-009 The block SHALL have port OutReady  input  1  consumer takes the result this cycle.
REQ-010 The block SHALL have port Result  output  WIDTH  signed registered result.
REQ-011 The block SHALL have ports Zero, Carry, Overflow  output  1 each  registered status flags.

Function
REQ-012 Transfer SHALL occur on InValid && InReady; output handoff SHALL occur on OutValid && OutReady.
REQ-013 Opcodes SHALL be: 000 pass Data1; 001 add; 010 AND; 011 OR; 100 sub (Data1-Data2); 101 XOR; 110 set-less-than signed (Result=1 if Data1<Data2, else 0); 111 multiply (see REQ-023).
REQ-014 States SHALL be IDLE and MUL; IDLE->MUL on accepted opcode 111; MUL->IDLE after WIDTH iteration cycles.
REQ-015 InReady SHALL be 1 only when state is IDLE and (OutValid==0 or OutReady==1).
REQ-016 Opcodes 000-110 SHALL load Result/flags and set OutValid on the edge of acceptance (OutValid visible 1 cycle later).
REQ-017 OutValid SHALL clear on handoff unless a new result loads on the same edge, in which case it stays 1 with new data.
REQ-018 While OutValid=1 and OutReady=0, Result, flags and OutValid SHALL hold unchanged.
REQ-019 Zero SHALL be 1 iff the WIDTH-bit Result is 0, for every opcode.
REQ-020 Add: Carry = unsigned carry-out of bit WIDTH-1; Overflow = signed overflow.
REQ-021 Sub: Carry = unsigned borrow (Data1<Data2 unsigned); Overflow = signed overflow.
REQ-022 Pass, AND, OR, XOR, set-less-than: Carry=0, Overflow=0.
REQ-023 Multiply: iterative shift-add, one partial product per cycle, WIDTH cycles in MUL; Result = low WIDTH bits of the signed 2*WIDTH product; Overflow=1 iff the product does not fit in signed WIDTH; Carry=0; OutValid asserts WIDTH+1 cycles after acceptance.
REQ-024 Operands SHALL be captured at acceptance; Data1/Data2/Select changes during MUL SHALL not affect the result.
REQ-025 InValid while InReady=0 SHALL be ignored (no capture, no error).

Reset
REQ-026 Reset_n low SHALL immediately force state IDLE, OutValid=0, Result=0, Zero=0, Carry=0, Overflow=0, and InReady=0.
REQ-027 Reset asserted mid-multiply SHALL abandon the operation; no result SHALL appear after release.
REQ-028 After Reset_n rises, InReady SHALL be 1 from the first rising edge onward.

Configuration
REQ-029 Macro ALU_PIPE_MUL_EN defined: opcode 111 SHALL behave per REQ-023.
REQ-030 Macro ALU_PIPE_MUL_EN undefined: no multiplier logic; opcode 111 SHALL complete as single-cycle with Result=0, Zero=1, Carry=0, Overflow=1; state SHALL never leave IDLE.

Verification (WIDTH=8, OutReady=1 unless stated)
REQ-031 Data1=0x81, Data2=0x3B, Select 000/001/010/011 -> Result 0x81 / 0xBC / 0x01 / 0xBB, each OutValid 1 cycle after acceptance, Carry=0, Overflow=0.
REQ-032 Sub 0x81-0x3B -> Result 0x46, Overflow=1, Carry=0; add 0x7F+0x01 -> 0x80, Overflow=1, Carry=0; add 0xFF+0x01 -> 0x00, Zero=1, Carry=1, Overflow=0.
REQ-033 MUL_EN defined: 0xFD*0x05 -> Result 0xF1, Overflow=0, InReady=0 for 8 cycles, OutValid 9 cycles after acceptance; 0x40*0x04 -> 0x00, Zero=1, Overflow=1.
REQ-034 OutReady=0 with OutValid=1 for 5 cycles while InValid=1 -> Result held, InReady=0, no new capture; OutReady=1 -> handoff and next operand accepted same edge.
REQ-035 Reset_n pulsed low 3 cycles into a multiply -> outputs zero immediately, no OutValid after release, next add accepted first edge after release.
REQ-036 MUL_EN undefined: Select 111 -> Result 0x00, Zero=1, Overflow=1, 1-cycle latency.
